// File: rtl/tick_1s_gen.sv
// Timebase divider: one-cycle tick every DIV clocks, a square wave that toggles
// on each tick, and a wrapping count of ticks since reset.
module tick_1s_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_MS     = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             s_o,
  output logic             sq_o,
  output logic [CNT_W-1:0] tick_count_o
);

  // 64-bit product: 50 MHz * 1000 ms overflows a 32-bit int.
  localparam longint DIV   = (longint'(CLK_FREQ_HZ) * longint'(TICK_MS)) / longint'(1000);
  localparam int     DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("tick_1s_gen: CLK_FREQ_HZ*TICK_MS/1000 must be at least 2");
  end

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             s_q, s_d;
  logic             sq_q, sq_d;
  logic [CNT_W-1:0] tick_count_q, tick_count_d;

  always_comb begin
    cnt_d        = cnt_q;
    s_d          = 1'b0;
    sq_d         = sq_q;
    tick_count_d = tick_count_q;
    if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d        = '0;
        s_d          = 1'b1;
        sq_d         = ~sq_q;
        tick_count_d = tick_count_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Reset wins over a tick landing on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      s_q          <= 1'b0;
      sq_q         <= 1'b0;
      tick_count_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      s_q          <= s_d;
      sq_q         <= sq_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign s_o          = s_q;
  assign sq_o         = sq_q;
  assign tick_count_o = tick_count_q;

endmodule

// File: tb/tb_tick_1s_gen.sv
// Bench for tick_1s_gen: DIV=10 main instance against an enabled-edge-count
// model, plus CNT_W=3 wrap, DIV=2 and DIV=10000 instances.
module tb_tick_1s_gen;

  localparam int DIV_M = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1, en_i = 1'b0;
  logic        s_o, sq_o;
  logic [15:0] tick_count_o;

  logic        rst_w = 1'b1, en_w = 1'b0;
  logic        s_w, sq_w;
  logic [2:0]  tc_w;

  logic        rst_2 = 1'b1, en_2 = 1'b0;
  logic        s_2, sq_2;
  logic [15:0] tc_2;

  logic        rst_b = 1'b1, en_b = 1'b0;
  logic        s_b, sq_b;
  logic [15:0] tc_b;

  tick_1s_gen #(.CLK_FREQ_HZ(1000), .TICK_MS(10), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .s_o(s_o), .sq_o(sq_o), .tick_count_o(tick_count_o));

  tick_1s_gen #(.CLK_FREQ_HZ(1000), .TICK_MS(10), .CNT_W(3)) u_wrap (
    .clk_i(clk), .rst_i(rst_w), .en_i(en_w),
    .s_o(s_w), .sq_o(sq_w), .tick_count_o(tc_w));

  tick_1s_gen #(.CLK_FREQ_HZ(2), .TICK_MS(1000), .CNT_W(16)) u_div2 (
    .clk_i(clk), .rst_i(rst_2), .en_i(en_2),
    .s_o(s_2), .sq_o(sq_2), .tick_count_o(tc_2));

  tick_1s_gen #(.CLK_FREQ_HZ(50_000), .TICK_MS(200), .CNT_W(16)) u_big (
    .clk_i(clk), .rst_i(rst_b), .en_i(en_b),
    .s_o(s_b), .sq_o(sq_b), .tick_count_o(tc_b));

  int checks   = 0;
  int failures = 0;

  // Model: expected outputs follow from the number of enabled edges since reset.
  int          m_n = 0;
  logic [17:0] sb_q[$];

  task automatic drive_main(input logic en, input logic rst);
    logic [17:0] e;
    en_i  = en;
    rst_i = rst;
    if (rst) m_n = 0;
    else if (en) m_n++;
    e = {(!rst && en && (m_n % DIV_M == 0)), 1'((m_n / DIV_M) % 2), 16'((m_n / DIV_M) % 65536)};
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [17:0] e;
    for (int i = 0; i < 3; i++) begin
      drive_main(1'b1, 1'b1);
      e = sb_q.pop_front();
      checks++;
      if ({s_o, sq_o, tick_count_o} !== e) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, {s_o, sq_o, tick_count_o}, e);
      end
    end
  endtask

  task automatic test_basic();
    logic [17:0] e;
    int tick_edges[$];
    drive_main(1'b1, 1'b1);
    void'(sb_q.pop_front());
    for (int c = 1; c <= 35; c++) begin
      drive_main(1'b1, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if ({s_o, sq_o, tick_count_o} !== e) begin
        failures++;
        $display("FAIL basic edge=%0d got=%h exp=%h", c, {s_o, sq_o, tick_count_o}, e);
      end
      if (s_o === 1'b1) tick_edges.push_back(c);
      if (c == 10 || c == 20 || c == 30) begin
        checks++;
        if (sq_o !== ((c == 20) ? 1'b0 : 1'b1)) begin
          failures++;
          $display("FAIL basic_sq edge=%0d got=%b", c, sq_o);
        end
      end
    end
    checks++;
    if (tick_edges.size() != 3 || tick_edges[0] != 10 || tick_edges[1] != 20 || tick_edges[2] != 30) begin
      failures++;
      $display("FAIL basic_tick_edges got_count=%0d exp=10,20,30", tick_edges.size());
    end
    checks++;
    if (tick_count_o !== 16'd3) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=3", tick_count_o);
    end
  endtask

  task automatic test_pause();
    logic [17:0] e;
    int first = -1;
    logic en;
    drive_main(1'b1, 1'b1);
    void'(sb_q.pop_front());
    for (int c = 1; c <= 25; c++) begin
      en = !(c >= 5 && c <= 11);
      drive_main(en, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if ({s_o, sq_o, tick_count_o} !== e) begin
        failures++;
        $display("FAIL pause edge=%0d got=%h exp=%h", c, {s_o, sq_o, tick_count_o}, e);
      end
      if (s_o === 1'b1 && first < 0) first = c;
    end
    checks++;
    if (first != 17) begin
      failures++;
      $display("FAIL pause_first_tick got=%0d exp=17", first);
    end
  endtask

  task automatic test_reset_at_tick();
    logic [17:0] e;
    int first = -1;
    drive_main(1'b1, 1'b1);
    void'(sb_q.pop_front());
    for (int c = 1; c <= 9; c++) begin
      drive_main(1'b1, 1'b0);
      void'(sb_q.pop_front());
    end
    drive_main(1'b1, 1'b1);
    e = sb_q.pop_front();
    checks++;
    if ({s_o, sq_o, tick_count_o} !== e) begin
      failures++;
      $display("FAIL rst_at_tick got=%h exp=%h", {s_o, sq_o, tick_count_o}, e);
    end
    for (int c = 1; c <= 12; c++) begin
      drive_main(1'b1, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if ({s_o, sq_o, tick_count_o} !== e) begin
        failures++;
        $display("FAIL rst_recover edge=%0d got=%h exp=%h", c, {s_o, sq_o, tick_count_o}, e);
      end
      if (s_o === 1'b1 && first < 0) first = c;
    end
    checks++;
    if (first != 10) begin
      failures++;
      $display("FAIL rst_next_tick got=%0d exp=10", first);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e;
    logic en, rst;
    for (int c = 0; c < 400; c++) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      drive_main(en, rst);
      e = sb_q.pop_front();
      checks++;
      if ({s_o, sq_o, tick_count_o} !== e) begin
        failures++;
        $display("FAIL random cyc=%0d en=%b rst=%b got=%h exp=%h", c, en, rst, {s_o, sq_o, tick_count_o}, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_tc_q[$];
    logic [2:0] e;
    int ticks = 0;
    for (int i = 0; i < 9; i++) exp_tc_q.push_back(3'((i + 1) % 8));
    rst_w = 1'b1; en_w = 1'b1;
    @(posedge clk); #1;
    rst_w = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      @(posedge clk); #1;
      if (s_w === 1'b1) begin
        ticks++;
        checks++;
        if (exp_tc_q.size() == 0 || (c % 10) != 0) begin
          failures++;
          $display("FAIL wrap_tick unexpected edge=%0d", c);
        end else begin
          e = exp_tc_q.pop_front();
          if (tc_w !== e) begin
            failures++;
            $display("FAIL wrap_count edge=%0d got=%0d exp=%0d", c, tc_w, e);
          end
        end
      end
    end
    checks++;
    if (ticks != 9) begin
      failures++;
      $display("FAIL wrap_ticks got=%0d exp=9", ticks);
    end
    rst_w = 1'b1; en_w = 1'b0;
  endtask

  task automatic test_div2();
    rst_2 = 1'b1; en_2 = 1'b1;
    @(posedge clk); #1;
    rst_2 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      checks++;
      if (s_2 !== 1'((c + 1) % 2 == 1) || sq_2 !== 1'((c / 2) % 2)) begin
        failures++;
        $display("FAIL div2 edge=%0d got s=%b sq=%b exp s=%b sq=%b", c, s_2, sq_2,
                 1'((c + 1) % 2 == 1), 1'((c / 2) % 2));
      end
    end
    checks++;
    if (tc_2 !== 16'd6) begin
      failures++;
      $display("FAIL div2_count got=%0d exp=6", tc_2);
    end
    rst_2 = 1'b1; en_2 = 1'b0;
  endtask

  task automatic test_long_period();
    int edges[$];
    rst_b = 1'b1; en_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    for (int c = 1; c <= 20005; c++) begin
      @(posedge clk); #1;
      if (s_b === 1'b1) edges.push_back(c);
    end
    checks++;
    if (edges.size() != 2 || edges[0] != 10000 || edges[1] != 20000) begin
      failures++;
      $display("FAIL long_period ticks=%0d first=%0d exp=10000,20000", edges.size(),
               (edges.size() > 0) ? edges[0] : -1);
    end
    rst_b = 1'b1; en_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_reset_at_tick();
    test_back_to_back();
    test_wrap();
    test_div2();
    test_long_period();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
